// File: rtl/cv_msg_packer.sv
// cv_msg_packer
// Upstream feeder for the per-round commitment hasher. Packs a stream of
// WORD_W-bit message words into the msgs bus (word 0 in the top slot),
// latches the session key/seed, runs the hasher's Hstart/en_end level
// handshake and hands the 256-bit commitment to the consumer over
// cv_valid/cv_ready. Rounds run back to back.
//
// Optional feature macro: ROUND_TAG_EN
//   defined   -> adds cv_round[15:0], a round counter that advances on each
//                commitment handshake and clears on sess_start / reset.
//   undefined -> no cv_round port and no counter.
//
// WORD_W * N_WORDS must equal 512 to match the hasher's message bus.

module cv_msg_packer #(
  parameter int WORD_W      = 32,
  parameter int N_WORDS     = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sess_start,
  input  logic [127:0]              key_in,
  input  logic [127:0]              seed_in,
  input  logic                      word_valid,
  input  logic [WORD_W-1:0]         word_in,
  output logic                      word_ready,
  output logic [127:0]              masked_key,
  output logic [127:0]              instseeds,
  output logic [WORD_W*N_WORDS-1:0] msgs,
  output logic                      Hstart,
  input  logic                      en_end,
  input  logic [255:0]              hashValue,
  output logic                      cv_valid,
  input  logic                      cv_ready,
  output logic [255:0]              cv_out,
  output logic                      busy,
  output logic                      err_timeout
`ifdef ROUND_TAG_EN
  ,
  output logic [15:0]               cv_round
`endif
);

  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Last watchdog value before expiry: Hstart stays high for exactly TIMEOUT_CYC cycles.
  localparam int WD_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_HASH,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WD_W-1:0]  wd_cnt;

  // Busy whenever a round is in flight, including a partially collected message.
  assign busy = (state != S_COLLECT) || (count != '0);

  // Round FSM: word collection, hasher handshake, watchdog and result hold.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_COLLECT;
      count       <= '0;
      wd_cnt      <= '0;
      word_ready  <= 1'b1;
      Hstart      <= 1'b0;
      cv_valid    <= 1'b0;
      cv_out      <= '0;
      masked_key  <= '0;
      instseeds   <= '0;
      err_timeout <= 1'b0;
      // NOTE: the message slots are ordinary output flops, not a RAM, so they
      // take the reset too; a partial message must not survive a reset.
      msgs        <= '0;
    end else begin
      unique case (state)
        S_COLLECT: begin
          if (sess_start) begin
            // A new session wins over a coincident word: the word is dropped.
            masked_key  <= key_in;
            instseeds   <= seed_in;
            count       <= '0;
            err_timeout <= 1'b0;
          end else if (word_valid) begin
            msgs[(N_WORDS - 1 - int'(count)) * WORD_W +: WORD_W] <= word_in;
            if (count == CNT_W'(N_WORDS - 1)) begin
              count      <= '0;
              wd_cnt     <= '0;
              word_ready <= 1'b0;
              Hstart     <= 1'b1;
              state      <= S_HASH;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end

        S_HASH: begin
          if (en_end) begin
            cv_out   <= hashValue;
            cv_valid <= 1'b1;
            Hstart   <= 1'b0;
            state    <= S_DONE;
          end else if ((TIMEOUT_CYC != 0) && (wd_cnt == WD_W'(WD_LAST))) begin
            // Hasher never answered: abandon the round without a result.
            err_timeout <= 1'b1;
            Hstart      <= 1'b0;
            word_ready  <= 1'b1;
            state       <= S_COLLECT;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        S_DONE: begin
          // Hstart is already low here, giving the hasher at least one cycle
          // to drop en_end before the next request.
          if (cv_ready) begin
            cv_valid   <= 1'b0;
            word_ready <= 1'b1;
            state      <= S_COLLECT;
          end
        end

        default: begin
          state      <= S_COLLECT;
          word_ready <= 1'b1;
          Hstart     <= 1'b0;
          cv_valid   <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROUND_TAG_EN
  // Round tag: counts accepted commitments, restarts with each session.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cv_round <= '0;
    end else if ((state == S_COLLECT) && sess_start) begin
      cv_round <= '0;
    end else if ((state == S_DONE) && cv_ready) begin
      cv_round <= cv_round + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cv_msg_packer.sv
// Self-checking bench for cv_msg_packer: directed rounds with a behavioural
// hasher and a scoreboard of expected commitments.

module tb_cv_msg_packer;

  localparam int TO = 20;

  logic         clk;
  logic         reset;
  logic         sess_start;
  logic [127:0] key_in;
  logic [127:0] seed_in;
  logic         word_valid;
  logic [31:0]  word_in;
  logic         word_ready;
  logic [127:0] masked_key;
  logic [127:0] instseeds;
  logic [511:0] msgs;
  logic         Hstart;
  logic         en_end;
  logic [255:0] hashValue;
  logic         cv_valid;
  logic         cv_ready;
  logic [255:0] cv_out;
  logic         busy;
  logic         err_timeout;
`ifdef ROUND_TAG_EN
  logic [15:0]  cv_round;
`endif

  int           n_pass  = 0;
  int           n_total = 0;
  logic [255:0] exp_cv_q[$];
  logic [127:0] exp_key;
  logic [127:0] exp_seed;
  int           exp_round;
  logic [255:0] hv_cur;
  bit           hasher_en;
  int           hs_cnt;

  cv_msg_packer #(
    .WORD_W      (32),
    .N_WORDS     (16),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sess_start  (sess_start),
    .key_in      (key_in),
    .seed_in     (seed_in),
    .word_valid  (word_valid),
    .word_in     (word_in),
    .word_ready  (word_ready),
    .masked_key  (masked_key),
    .instseeds   (instseeds),
    .msgs        (msgs),
    .Hstart      (Hstart),
    .en_end      (en_end),
    .hashValue   (hashValue),
    .cv_valid    (cv_valid),
    .cv_ready    (cv_ready),
    .cv_out      (cv_out),
    .busy        (busy),
    .err_timeout (err_timeout)
`ifdef ROUND_TAG_EN
    ,
    .cv_round    (cv_round)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hasher model: raises en_end with hv_cur on the 5th cycle of Hstart,
  // drops it once Hstart falls.
  initial begin
    en_end    = 1'b0;
    hashValue = '0;
    hs_cnt    = 0;
    forever begin
      @(negedge clk);
      if (hasher_en && Hstart === 1'b1) begin
        hs_cnt++;
        if (hs_cnt == 5) begin
          en_end    = 1'b1;
          hashValue = hv_cur;
        end
      end else begin
        hs_cnt = 0;
        en_end = 1'b0;
      end
    end
  end

  // Hard stop in case something wedges beyond the per-wait bounds.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [511:0] build_msg(input logic [31:0] base);
    logic [511:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[(15 - i) * 32 +: 32] = base + 32'(i);
    return m;
  endfunction

  task automatic start_session(input logic [127:0] k, input logic [127:0] s, input bit with_word);
    sess_start = 1'b1;
    key_in     = k;
    seed_in    = s;
    word_valid = with_word;
    word_in    = 32'hDEAD_BEEF;
    @(negedge clk);
    sess_start = 1'b0;
    word_valid = 1'b0;
    exp_key    = k;
    exp_seed   = s;
    exp_round  = 0;
  endtask

  // Drives n words base+first.. ; optional idle gaps between words.
  task automatic drive_words(input logic [31:0] base, input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        word_valid = 1'b0;
        @(negedge clk);
      end
      word_valid = 1'b1;
      word_in    = base + 32'(i);
      @(negedge clk);
    end
    word_valid = 1'b0;
  endtask

  // Full round: 16 words, hasher reply, commitment held for 'hold' cycles, then accepted.
  task automatic run_round(input string tag, input logic [31:0] base, input logic [255:0] hv,
                           input bit gaps, input int hold);
    logic [255:0] exp_cv;
    int           n;
    bit           stable;
    exp_cv_q.push_back(hv);
    hv_cur = hv;
    drive_words(base, 0, 15, gaps);
    word_valid = 1'b1;
    word_in    = base + 32'd15;
    check({tag, "_hstart_pre"}, Hstart, 1'b0);
    @(negedge clk);
    word_valid = 1'b0;
    check({tag, "_hstart_rise"}, Hstart, 1'b1);
    check({tag, "_msgs"}, msgs, build_msg(base));
    check({tag, "_key"}, masked_key, exp_key);
    check({tag, "_seed"}, instseeds, exp_seed);
    check({tag, "_word_ready_hash"}, word_ready, 1'b0);
    n = 0;
    while (cv_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cv_latency"}, n, 5);
    check({tag, "_hstart_fall"}, Hstart, 1'b0);
    if (exp_cv_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1'b1, 1'b0);
      exp_cv = '0;
    end else begin
      exp_cv = exp_cv_q.pop_front();
    end
    check({tag, "_cv_out"}, cv_out, exp_cv);
`ifdef ROUND_TAG_EN
    check({tag, "_cv_round"}, cv_round, 16'(exp_round));
`endif
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (cv_valid !== 1'b1 || cv_out !== exp_cv || word_ready !== 1'b0 || Hstart !== 1'b0)
        stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, stable, 1'b1);
    cv_ready = 1'b1;
    @(negedge clk);
    cv_ready = 1'b0;
    exp_round++;
    check({tag, "_cv_valid_clear"}, cv_valid, 1'b0);
    check({tag, "_word_ready_back"}, word_ready, 1'b1);
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    sess_start = 1'b0;
    key_in     = '0;
    seed_in    = '0;
    word_valid = 1'b0;
    word_in    = '0;
    cv_ready   = 1'b0;
    hasher_en  = 1'b1;
    hv_cur     = '0;
    exp_key    = '0;
    exp_seed   = '0;
    exp_round  = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_word_ready", word_ready, 1'b1);
    check("rst_hstart", Hstart, 1'b0);
    check("rst_cv_valid", cv_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_msgs", msgs, '0);
    check("rst_err", err_timeout, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Test 1-3: first round, commitment held 10 cycles before acceptance
    start_session(128'h0123456789ABCDEF0123456789ABCDEF, 128'hFEDCBA98765432100011223344556677, 1'b0);
    run_round("r1", 32'h0, {32{8'hAA}}, 1'b0, 10);
    check("r1_msgs_top", msgs[511:480], 32'h0);
    check("r1_msgs_bot", msgs[31:0], 32'hF);

    // Test 4: three back-to-back rounds with random word gaps
    run_round("b0", 32'h0000_0100, {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
    run_round("b1", 32'h0000_0200, {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
    run_round("b2", 32'h0000_0300, {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom}, 1'b1, 0);

    // sess_start colliding with a word: word dropped, partial message discarded
    drive_words(32'h0000_0500, 0, 3, 1'b0);
    check("coll_busy_partial", busy, 1'b1);
    start_session(128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h9, 1'b1);
    check("coll_busy_cleared", busy, 1'b0);
    run_round("coll", 32'h0000_0600, {8{32'h5A5A_0001}}, 1'b0, 0);

    // Test 5: hasher silent -> watchdog
    hasher_en = 1'b0;
    drive_words(32'h0000_0700, 0, 16, 1'b0);
    check("to_hstart_rise", Hstart, 1'b1);
    n = 0;
    while (Hstart === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_hstart_cycles", n, TO);
    check("to_err", err_timeout, 1'b1);
    check("to_no_cv_valid", cv_valid, 1'b0);
    check("to_word_ready", word_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("to_err_sticky", err_timeout, 1'b1);
    start_session(128'hCAFE, 128'hBEEF, 1'b0);
    check("to_err_cleared", err_timeout, 1'b0);
    hasher_en = 1'b1;

    // Test 6: async reset after 7 words
    drive_words(32'h0000_0800, 0, 7, 1'b0);
    check("r6_busy_partial", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("r6_busy", busy, 1'b0);
    check("r6_msgs", msgs, '0);
    check("r6_word_ready", word_ready, 1'b1);
    check("r6_key", masked_key, '0);
    check("r6_hstart", Hstart, 1'b0);
    @(negedge clk);
    reset     = 1'b1;
    exp_key   = '0;
    exp_seed  = '0;
    exp_round = 0;
    @(negedge clk);
    run_round("r6", 32'h0000_0900, {16{16'hC3C3}}, 1'b0, 0);

    check("end_scoreboard_empty", exp_cv_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
